// File: rtl/mem_bus_pkg.sv
// Shared bus definitions for the byte-addressed memory responder.
// Access size codes, FSM state encoding and a size-to-bytes helper.
package mem_bus_pkg;

    localparam logic [2:0] SZ_BYTE = 3'd0;
    localparam logic [2:0] SZ_HALF = 3'd1;
    localparam logic [2:0] SZ_WORD = 3'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    function automatic logic [2:0] size_bytes(input logic [2:0] sz);
        logic [2:0] n;
        case (sz)
            SZ_BYTE: n = 3'd1;
            SZ_HALF: n = 3'd2;
            default: n = 3'd4;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/mem_responder_store.sv
// Byte array with four independent write lanes and one aligned
// 32-bit little-endian read port.
module mem_responder_store #(
    parameter int DEPTH = 4096,
    parameter int AW    = 12
) (
    input  logic            clk,
    input  logic [3:0]      we,
    input  logic [4*AW-1:0] widx,
    input  logic [31:0]     wbyte,
    input  logic [AW-1:0]   ridx,
    output logic [31:0]     rword
);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] r1;
    logic [AW-1:0] r2;
    logic [AW-1:0] r3;

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we[i]) begin
                mem[widx[i*AW +: AW]] <= wbyte[i*8 +: 8];
            end
        end
    end

    assign r1 = ridx + AW'(1);
    assign r2 = ridx + AW'(2);
    assign r3 = ridx + AW'(3);

    assign rword = {mem[r3], mem[r2], mem[r1], mem[ridx]};

endmodule

// File: rtl/mem_responder.sv
// Single-port memory responder: captures one request, optionally waits,
// then pulses ready (with err on illegal/out-of-range accesses).
module mem_responder #(
    parameter logic [31:0] BASE  = 32'h0000_1000,
    parameter int          DEPTH = 4096,
    parameter int          WAIT  = 0
) (
    input  logic        clk,
    input  logic        rstb,
    input  logic [31:0] addr,
    input  logic [2:0]  size,
    input  logic        valid,
    input  logic        write,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        err
);
    import mem_bus_pkg::*;

    localparam int            AW  = $clog2(DEPTH);
    localparam logic [32:0]   LO  = {1'b0, BASE};
    localparam logic [32:0]   HI  = LO + 33'(DEPTH) - 33'd1;
    localparam logic [AW-1:0] BLO = BASE[AW-1:0];
    localparam logic [3:0]    WLD = 4'(WAIT - 1);

    state_t          state_q;
    state_t          state_d;
    logic [3:0]      cnt_q;
    logic [3:0]      cnt_d;

    logic [31:0]     addr_q;
    logic [31:0]     wdata_q;
    logic [2:0]      size_q;
    logic            write_q;

    logic [31:0]     src_addr;
    logic [2:0]      src_size;
    logic            src_write;
    logic            src_err;
    logic [32:0]     first;
    logic [32:0]     last;
    logic [2:0]      nb;

    logic            ready_q;
    logic            err_q;
    logic [31:0]     rdata_q;

    logic [AW-1:0]   ridx;
    logic [AW-1:0]   woff;
    logic [4*AW-1:0] widx;
    logic [3:0]      we;
    logic            commit;
    logic [31:0]     rword;

    // In IDLE the live inputs are the request; afterwards the captured copy.
    always_comb begin
        src_addr  = addr_q;
        src_size  = size_q;
        src_write = write_q;
        if (state_q == ST_IDLE) begin
            src_addr  = addr;
            src_size  = size;
            src_write = write;
        end
    end

    // 33-bit span check so a wrap past the top of memory is caught.
    always_comb begin
        first = {1'b0, src_addr[31:2], 2'b00};
        nb    = 3'd4;
        if (src_write) begin
            first = {1'b0, src_addr};
            nb    = size_bytes(src_size);
        end
        last    = first + {30'd0, nb} - 33'd1;
        src_err = (src_size > SZ_WORD) || (first < LO) || (last > HI);
    end

    assign ridx = {src_addr[AW-1:2], 2'b00} - BLO;
    assign woff = addr_q[AW-1:0] - BLO;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (valid) begin
                    if (WAIT > 0) begin
                        state_d = ST_WAIT;
                        cnt_d   = WLD;
                    end else begin
                        state_d = ST_RESP;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstb) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= (state_d == ST_RESP);
            err_q   <= (state_d == ST_RESP) && src_err;
            if (state_d == ST_RESP) begin
                if (src_err) begin
                    rdata_q <= 32'd0;
                end else if (!src_write) begin
                    rdata_q <= rword;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == ST_IDLE && valid) begin
            addr_q  <= addr;
            size_q  <= size;
            write_q <= write;
            wdata_q <= wdata;
        end
    end

    // A reset landing on the ready cycle still drops the write.
    assign commit = ready_q && write_q && !err_q && rstb;

    always_comb begin
        we[0] = commit;
        we[1] = commit && (size_q != SZ_BYTE);
        we[2] = commit && (size_q == SZ_WORD);
        we[3] = commit && (size_q == SZ_WORD);
        for (int i = 0; i < 4; i++) begin
            widx[i*AW +: AW] = woff + AW'(i);
        end
    end

    mem_responder_store #(
        .DEPTH(DEPTH),
        .AW   (AW)
    ) u_store (
        .clk  (clk),
        .we   (we),
        .widx (widx),
        .wbyte(wdata_q),
        .ridx (ridx),
        .rword(rword)
    );

    assign ready = ready_q;
    assign err   = err_q;
    assign rdata = rdata_q;

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter BASE, 32'h0000_1000, lowest byte address served.
REQ-002 Parameter DEPTH, 4096, number of bytes stored; served range is BASE to BASE+DEPTH-1.
REQ-003 Parameter WAIT, 0, extra wait cycles inserted before ready, range 0..15.
REQ-004 Port clk  input  1  single clock; all logic on its rising edge.
REQ-005 Port rstb  input  1  reset, synchronous, active-low.
REQ-006 Port addr  input  32  byte address of request.
REQ-007 Port size  input  3  access size: 0 byte, 1 halfword, 2 word; other codes illegal.
REQ-008 Port valid  input  1  request present; initiator holds addr/size/write/wdata stable until ready.
REQ-009 Port write  input  1  1 = write, 0 = read.
REQ-010 Port wdata  input  32  write data, little-endian lanes: [7:0] to addr, [15:8] to addr+1, [31:16] to addr+2/addr+3.
REQ-011 Port rdata  output  32  read data for the aligned word containing addr.
REQ-012 Port ready  output  1  one-cycle completion pulse.
REQ-013 Port err  output  1  one-cycle error flag, coincident with ready.

Function
REQ-014 FSM states: IDLE, WAIT, RESP; reset state IDLE.
REQ-015 IDLE: valid=1 captures addr/size/write/wdata; go to WAIT if WAIT>0, else RESP; valid=0 stays IDLE.
REQ-016 WAIT: down-counter loaded with WAIT-1 on entry; go to RESP when it reaches 0; counter width 4 bits.
REQ-017 RESP: ready=1 for exactly this cycle; next state IDLE unconditionally.
REQ-018 Latency: ready rises WAIT+1 cycles after the cycle valid is first sampled in IDLE.
REQ-019 Back-to-back: valid still high in the cycle after ready is treated as a new request; min request period WAIT+2 cycles.
REQ-020 Read: rdata = {mem[A+3],mem[A+2],mem[A+1],mem[A]}, A = {addr[31:2],2'b00} minus BASE, registered and valid in the ready cycle; size ignored for lane selection.
REQ-021 rdata holds its last value except when a legal read completes.
REQ-022 Write: byte mem[addr] always; mem[addr+1] if size>=1; mem[addr+2], mem[addr+3] if size==2; committed on the ready cycle.
REQ-023 Misaligned writes permitted; a halfword or word may straddle a word boundary.
REQ-024 Error when size>2, or any touched byte (read: whole aligned word; write: every written byte) lies outside BASE..BASE+DEPTH-1; address arithmetic in 33 bits so addr+3 wrap past 32'hFFFF_FFFF counts as out of range.
REQ-025 On error: ready and err both 1 for one cycle, no memory byte modified, rdata forced to 0.
REQ-026 err=0 whenever ready=0.
REQ-027 Changes on addr/size/write/wdata after capture have no effect on the pending access.

Reset
REQ-028 rstb=0 at a rising edge: state IDLE, ready=0, err=0, rdata=0, wait counter=0.
REQ-029 Reset during WAIT or RESP aborts the access; a write not yet committed is dropped; no ready is issued.
REQ-030 Memory contents are not reset.

Structure
REQ-031 Shared package mem_bus_pkg holds size codes SZ_BYTE=0, SZ_HALF=1, SZ_WORD=2 and the FSM state enum.
REQ-032 Sub-module mem_responder_store: DEPTH-byte array, 4-lane write enables with per-lane byte index, aligned 32-bit read port; FSM, range check and capture registers stay in mem_responder.

Verification
REQ-033 WAIT=0, write word 32'h7469_6873 at 'h1100, read 'h1100 -> ready 1 cycle after valid, rdata=32'h7469_6873, err=0.
REQ-034 Write byte 8'h21 at 'h1304 into word 32'h0 at 'h1304, then read 'h1305 -> rdata=32'h0000_0021.
REQ-035 Halfword 16'hBEEF at 'h1103 (straddle) -> bytes 'h1103='hEF, 'h1104='hBE, neighbours unchanged.
REQ-036 Read 'h0FFC, write word at BASE+DEPTH-2, size=3 at 'h1100 -> each ready+err, rdata=0, memory unchanged.
REQ-037 WAIT=3, valid held high for two requests -> ready at cycles 4 and 9 after first valid, no extra ready.
REQ-038 WAIT=3, rstb low in WAIT of a write to 'h1200 -> no ready, 'h1200 retains old value, ready=err=rdata=0 after reset.
